// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// h_cnt_q/v_cnt_q hold the raster position presented at the next enabled
// edge. Every output register is loaded from that same position in the same
// cycle, so sync, de, coordinates and strobes never skew against each other.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          VGA_CLK,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  // Raster boundaries, all compared unsigned at counter width.
  localparam logic [XW-1:0] X_ZERO   = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO   = {YW{1'b0}};
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT_Y  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic [XW-1:0] pixel_x_q, pixel_x_d;
  logic [YW-1:0] pixel_y_q, pixel_y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next state: present the counter position and advance, or hold with strobes cleared.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      de_d          = (h_cnt_q < H_ACT_X) && (v_cnt_q < V_ACT_Y);
      hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = (h_cnt_q == X_ZERO);
      frame_start_d = (h_cnt_q == X_ZERO) && (v_cnt_q == Y_ZERO);
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = X_ZERO;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = Y_ZERO;
        end else begin
          v_cnt_d = v_cnt_q + Y_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + X_ONE;
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end
  end

  // State and output registers; reset aborts the frame and idles the syncs.
  always_ff @(posedge VGA_CLK) begin
    if (rst) begin
      h_cnt_q       <= X_ZERO;
      v_cnt_q       <= Y_ZERO;
      pixel_x_q     <= X_ZERO;
      pixel_y_q     <= Y_ZERO;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Instance A uses the default 640x480 timing, instance B a tiny raster
// (H 8/2/2/2, V 4/1/1/1, HS_POL=1) so whole frames fit in a short run.
module tb_vga_timing_gen;

  typedef struct {
    logic hs, vs, de, ls, fs;
    int   x, y;
  } out_t;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    bit valid;
    int x, y, nx, ny;
  } mst_t;

  typedef struct {
    bit   r, e;
    out_t o;
  } vec_t;

  logic VGA_CLK = 1'b0;
  always #20 VGA_CLK = ~VGA_CLK;

  logic rst_a = 1'b1, en_a = 1'b1, rst_b = 1'b1, en_b = 1'b1;
  logic hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0] x_b;
  logic [2:0] y_b;

  vga_timing_gen dut_a (
    .VGA_CLK(VGA_CLK), .rst(rst_a), .en(en_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .pixel_x(x_a), .pixel_y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
  ) dut_b (
    .VGA_CLK(VGA_CLK), .rst(rst_b), .en(en_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .pixel_x(x_b), .pixel_y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int kb = 0;
  cfg_t cfg_a, cfg_b;
  mst_t ms_a, ms_b;
  out_t q_a[$];
  out_t q_b[$];

  // period bookkeeping
  bit lclean_a = 1'b0, fclean_b = 1'b0;
  int last_ls_a = 0, de_cnt_a = 0, hsl_cnt_a = 0;
  int last_fs_b = 0, de_cnt_b = 0, vsl_cnt_b = 0, hsh_cnt_b = 0;

  // Reference raster model: returns expected outputs after one clock edge.
  task automatic model_step(input cfg_t c, input bit r, input bit e, inout mst_t s, output out_t o);
    int ht, vt, hs0, vs0;
    bit stb;
    ht  = c.ha + c.hf + c.hsw + c.hb;
    vt  = c.va + c.vf + c.vsw + c.vb;
    hs0 = c.ha + c.hf;
    vs0 = c.va + c.vf;
    stb = 1'b0;
    if (r) begin
      s.valid = 1'b0; s.x = 0; s.y = 0; s.nx = 0; s.ny = 0;
    end else if (e) begin
      s.valid = 1'b1; s.x = s.nx; s.y = s.ny; stb = 1'b1;
      s.nx = s.nx + 1;
      if (s.nx == ht) begin
        s.nx = 0;
        s.ny = s.ny + 1;
        if (s.ny == vt) s.ny = 0;
      end
    end
    if (!s.valid) begin
      o.hs = !c.hp; o.vs = !c.vp; o.de = 1'b0; o.ls = 1'b0; o.fs = 1'b0; o.x = 0; o.y = 0;
    end else begin
      o.x  = s.x;
      o.y  = s.y;
      o.de = (s.x < c.ha) && (s.y < c.va);
      o.hs = ((s.x >= hs0) && (s.x < hs0 + c.hsw)) ? c.hp : !c.hp;
      o.vs = ((s.y >= vs0) && (s.y < vs0 + c.vsw)) ? c.vp : !c.vp;
      o.ls = stb && (s.x == 0);
      o.fs = stb && (s.x == 0) && (s.y == 0);
    end
  endtask

  task automatic check(input string nm, input out_t e, input logic hs, input logic vs,
                       input logic de, input logic ls, input logic fs,
                       input logic [15:0] x, input logic [15:0] y);
    n_checks++;
    if (hs !== e.hs || vs !== e.vs || de !== e.de || ls !== e.ls || fs !== e.fs ||
        x !== 16'(e.x) || y !== 16'(e.y)) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
               nm, cyc, x, y, hs, vs, de, ls, fs, e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs);
    end
  endtask

  // One clock: drive both instances, queue expectations, compare after the edge.
  task automatic step(input bit ra, input bit ea, input bit rb, input bit eb,
                      input bit use_tab, input out_t tab);
    out_t oa, ob, pa, pb;
    rst_a = ra; en_a = ea; rst_b = rb; en_b = eb;
    model_step(cfg_a, ra, ea, ms_a, oa);
    model_step(cfg_b, rb, eb, ms_b, ob);
    if (use_tab) q_a.push_back(tab);
    else         q_a.push_back(oa);
    q_b.push_back(ob);
    if (ra || !ea) lclean_a = 1'b0;
    if (rb || !eb) fclean_b = 1'b0;
    @(posedge VGA_CLK);
    #1;
    cyc++;
    pa = q_a.pop_front();
    pb = q_b.pop_front();
    check(use_tab ? "table_a" : "model_a", pa, hs_a, vs_a, de_a, ls_a, fs_a, {6'd0, x_a}, {6'd0, y_a});
    check("model_b", pb, hs_b, vs_b, de_b, ls_b, fs_b, {12'd0, x_b}, {13'd0, y_b});
    if (ls_a === 1'b1) begin
      if (lclean_a) begin
        n_checks++;
        if (cyc - last_ls_a != 800 || de_cnt_a != 640 || hsl_cnt_a != 96) begin
          n_fail++;
          $display("FAIL line_a got period=%0d de=%0d hs_low=%0d, expected 800/640/96",
                   cyc - last_ls_a, de_cnt_a, hsl_cnt_a);
        end
      end
      last_ls_a = cyc; de_cnt_a = 0; hsl_cnt_a = 0; lclean_a = 1'b1;
    end
    if (de_a === 1'b1) de_cnt_a++;
    if (hs_a === 1'b0) hsl_cnt_a++;
    if (fs_b === 1'b1) begin
      if (fclean_b) begin
        n_checks++;
        if (cyc - last_fs_b != 98 || de_cnt_b != 32 || vsl_cnt_b != 14 || hsh_cnt_b != 14) begin
          n_fail++;
          $display("FAIL frame_b got period=%0d de=%0d vs_low=%0d hs_high=%0d, expected 98/32/14/14",
                   cyc - last_fs_b, de_cnt_b, vsl_cnt_b, hsh_cnt_b);
        end
      end
      last_fs_b = cyc; de_cnt_b = 0; vsl_cnt_b = 0; hsh_cnt_b = 0; fclean_b = 1'b1;
    end
    if (de_b === 1'b1) de_cnt_b++;
    if (vs_b === 1'b0) vsl_cnt_b++;
    if (hs_b === 1'b1) hsh_cnt_b++;
  endtask

  // Drive instance A as asked; B follows its own schedule (resets, en gap).
  task automatic run_a(input bit ra, input bit ea, input int n);
    out_t dummy;
    dummy = '{default: 0};
    for (int i = 0; i < n; i++) begin
      step(ra, ea, (kb == 0) || (kb == 500), !((kb >= 300) && (kb < 305)), 1'b0, dummy);
      kb++;
    end
  endtask

  function automatic vec_t mk(input bit r, input bit e, input int x, input int y,
                              input logic de, input logic hs, input logic vs,
                              input logic ls, input logic fs);
    vec_t v;
    v.r = r; v.e = e;
    v.o.x = x; v.o.y = y; v.o.de = de; v.o.hs = hs; v.o.vs = vs; v.o.ls = ls; v.o.fs = fs;
    return v;
  endfunction

  initial begin
    vec_t tab[15];
    bit reached;
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_b = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0};
    ms_a  = '{default: 0};
    ms_b  = '{default: 0};

    // reset, release to (0,0), freeze, reset with en low, restart
    for (int i = 0; i < 5; i++) tab[i] = mk(1, 1, 0, 0, 0, 1, 1, 0, 0);
    tab[5]  = mk(0, 1, 0, 0, 1, 1, 1, 1, 1);
    tab[6]  = mk(0, 1, 1, 0, 1, 1, 1, 0, 0);
    tab[7]  = mk(0, 0, 1, 0, 1, 1, 1, 0, 0);
    tab[8]  = mk(0, 0, 1, 0, 1, 1, 1, 0, 0);
    tab[9]  = mk(0, 1, 2, 0, 1, 1, 1, 0, 0);
    tab[10] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tab[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tab[12] = mk(0, 1, 0, 0, 1, 1, 1, 1, 1);
    tab[13] = mk(0, 1, 1, 0, 1, 1, 1, 0, 0);
    tab[14] = mk(1, 1, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(tab[i].r, tab[i].e, 1'b1, 1'b1, 1'b1, tab[i].o);

    // one full line plus wrap into line 1, then continue to x=700,y=1
    run_a(1'b0, 1'b1, 1000);
    run_a(1'b0, 1'b1, 501);
    // freeze for 10 cycles, then resume
    run_a(1'b0, 1'b0, 10);
    run_a(1'b0, 1'b1, 50);

    // advance to x=300,y=2 then reset for one cycle
    reached = (ms_a.x == 300) && (ms_a.y == 2);
    for (int i = 0; i < 2000 && !reached; i++) begin
      run_a(1'b0, 1'b1, 1);
      reached = (ms_a.x == 300) && (ms_a.y == 2);
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL reach_300_2 got x=%0d y=%0d, expected x=300 y=2", ms_a.x, ms_a.y);
    end
    run_a(1'b1, 1'b1, 1);
    run_a(1'b0, 1'b1, 1700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
